// File: rtl/capture_ctrl_if.sv
// Command/trigger/RAM-side signals of capture_ctrl. Under CAPTURE_AUTO_TRIG_EN the
// auto-trigger timeout value and status flag are carried as well.
interface capture_ctrl_if #(
    parameter int AW = 9
`ifdef CAPTURE_AUTO_TRIG_EN
    , parameter int TMO_W = 16
`endif
);
    logic          capture_start;
    logic          capture_abort;
    logic          en_sample;
    logic [AW-1:0] trig_pos;
    logic          triggered;
    logic          clr_cap_done;
    logic          trig_en;
    logic          armed;
    logic          set_cap_done;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] trace_end;
    logic          cap_done;
`ifdef CAPTURE_AUTO_TRIG_EN
    logic [TMO_W-1:0] tmo_val;
    logic             auto_trig;
`endif

    modport master (
        output capture_start, capture_abort, en_sample, trig_pos, triggered, clr_cap_done,
        input  trig_en, armed, set_cap_done, we, waddr, trace_end, cap_done
`ifdef CAPTURE_AUTO_TRIG_EN
        , output tmo_val, input auto_trig
`endif
    );

    modport slave (
        input  capture_start, capture_abort, en_sample, trig_pos, triggered, clr_cap_done,
        output trig_en, armed, set_cap_done, we, waddr, trace_end, cap_done
`ifdef CAPTURE_AUTO_TRIG_EN
        , input tmo_val, output auto_trig
`endif
    );
endinterface

// File: rtl/capture_ctrl.sv
// Scope capture sequencer: pre-trigger fill, armed wait, post-trigger count, done.
// Optional timeout auto-trigger in ARM is built with CAPTURE_AUTO_TRIG_EN.
module capture_ctrl #(
    parameter int ENTRIES = 512,
    parameter int AW      = 9,
    parameter int TMO_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    capture_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PRE, ARM, POST, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW:0]   cnt, cnt_nxt, cnt_inc;
    logic [AW:0]   pre_len;
    logic [AW-1:0] post_len;
    logic [AW-1:0] waddr, waddr_nxt;
    logic [AW-1:0] trace_end;
    logic          set_cap_done_q;
    logic          writing;
    logic          start_ok;
    logic          trig_hit;
    logic          done_evt;

    // trig_pos is AW bits wide so it can never exceed ENTRIES-1; no clamp needed.
    assign pre_len = (AW+1)'(ENTRIES) - {1'b0, post_len};
    assign cnt_inc = cnt + (AW+1)'(1);

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_inc;
    logic             tmo_hit;
    logic             auto_trig_q;

    assign tmo_inc = tmo_cnt + TMO_W'(1);
    assign tmo_hit = (state == ARM) && bus.en_sample && (bus.tmo_val != '0)
                     && (tmo_inc == bus.tmo_val);
    assign trig_hit = bus.triggered || tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            auto_trig_q <= 1'b0;
        end else begin
            if (state != ARM)
                tmo_cnt <= '0;
            else if (bus.en_sample)
                tmo_cnt <= tmo_inc;
            if (start_ok && !bus.capture_abort)
                auto_trig_q <= 1'b0;
            else if (tmo_hit && !bus.triggered && !bus.capture_abort)
                auto_trig_q <= 1'b1;
        end
    end

    assign bus.auto_trig = auto_trig_q;
`else
    logic [TMO_W-1:0] unused_tmo;
    assign unused_tmo = '0;
    assign trig_hit   = bus.triggered;
`endif

    // A zero-length post phase exits without touching the RAM.
    always_comb begin
        writing   = bus.en_sample && ((state == PRE) || (state == ARM) ||
                                      ((state == POST) && (post_len != '0)));
        waddr_nxt = writing ? waddr + AW'(1) : waddr;
        start_ok  = bus.capture_start && ((state == IDLE) || (state == DONE));
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_evt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start_ok) state_nxt = PRE;
            end
            PRE: begin
                if (writing) begin
                    if (cnt_inc == pre_len) begin
                        state_nxt = ARM;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            ARM: begin
                if (trig_hit) begin
                    state_nxt = POST;
                    cnt_nxt   = '0;
                end
            end
            POST: begin
                if (post_len == '0) begin
                    state_nxt = DONE;
                    done_evt  = 1'b1;
                end else if (writing) begin
                    if (cnt_inc == {1'b0, post_len}) begin
                        state_nxt = DONE;
                        done_evt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            DONE: begin
                if (start_ok) begin
                    state_nxt = PRE;
                    cnt_nxt   = '0;
                end else if (bus.clr_cap_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.capture_abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_evt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            waddr          <= '0;
            post_len       <= '0;
            trace_end      <= '0;
            set_cap_done_q <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            waddr          <= waddr_nxt;
            set_cap_done_q <= done_evt;
            if (start_ok && !bus.capture_abort)
                post_len <= bus.trig_pos;
            if (done_evt)
                trace_end <= waddr_nxt - AW'(1);
        end
    end

    assign bus.we           = writing;
    assign bus.waddr        = waddr;
    assign bus.trace_end    = trace_end;
    assign bus.trig_en      = (state == PRE) || (state == ARM) || (state == POST);
    assign bus.armed        = (state == ARM);
    assign bus.cap_done     = (state == DONE);
    assign bus.set_cap_done = set_cap_done_q;
endmodule
